// File: rtl/lcd_text_ctrl.sv
// HD44780-class character LCD controller: power-up/init sequence, LINES x COLS text buffer,
// continuous refresh onto the 8-bit bus. Optional feature macro: LCD_DIRTY_EN (refresh only after writes).
module lcd_text_ctrl #(
    parameter int CLK_DIV       = 5,
    parameter int COLS          = 16,
    parameter int LINES         = 2,
    parameter int POWERUP_SLOTS = 70,
    parameter int CMD_SLOTS     = 30,
    parameter int CLEAR_SLOTS   = 200,
    parameter int GAP_SLOTS     = 400
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [$clog2(LINES*COLS+1)-1:0]     wr_addr,
    input  logic [7:0]                          wr_data,
    output logic                                ready,
    output logic                                frame_done,
    output logic                                lcd_e,
    output logic                                lcd_rs,
    output logic                                lcd_rw,
    output logic [7:0]                          lcd_data
);
    // Address is one bit wider than strictly needed so the first out-of-range index is expressible.
    localparam int N   = LINES * COLS;
    localparam int AW  = $clog2(N + 1);
    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int DW  = $clog2(2 * CLK_DIV);
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [DW-1:0]  DIV_LAST  = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0]  DIV_HALF  = DW'(CLK_DIV);
    localparam logic [15:0]    PWR_LAST  = 16'(POWERUP_SLOTS - 1);
    localparam logic [15:0]    CMD_LAST  = 16'(CMD_SLOTS - 1);
    localparam logic [15:0]    CLR_LAST  = 16'(CLEAR_SLOTS - 1);
    localparam logic [15:0]    GAP_LAST  = 16'(GAP_SLOTS - 1);
    localparam logic [CLW-1:0] COL_LAST  = CLW'(COLS - 1);
    localparam logic           LINE_LAST = 1'(LINES - 1);
    localparam logic [7:0]     FUNC_CMD  = (LINES == 2) ? 8'h38 : 8'h30;

    typedef enum logic [2:0] {
        S_PWRUP, S_FUNC, S_DISP, S_ENTRY, S_CLEAR, S_LADDR, S_CHARS, S_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  div_q, div_d;
    logic [15:0]    cnt_q, cnt_d;
    logic           line_q, line_d;
    logic [CLW-1:0] col_q, col_d;
    logic [7:0]     text_q [N];
    logic           tick, wr_ok, go, gap_end, frame_end, strobe_d;
    logic [IW-1:0]  rd_idx;

    logic           lcd_e_q, lcd_rs_q, ready_q, frame_done_q;
    logic [7:0]     lcd_data_q;
    logic           e_d, rs_d, ready_d, frame_done_d;
    logic [7:0]     data_d;

    assign tick      = (div_q == DIV_LAST);
    assign wr_ok     = wr_en && (wr_addr < AW'(N));
    assign gap_end   = (GAP_SLOTS <= 1) ? 1'b1 : (cnt_q >= GAP_LAST);
    assign frame_end = tick && (state_q == S_CHARS) && (col_q == COL_LAST) && (line_q == LINE_LAST);

`ifdef LCD_DIRTY_EN
    logic dirty_q, frame_start;
    // A write landing on the same edge as the frame-start clear wins.
    assign frame_start = tick && (state_d == S_LADDR) && !line_d;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dirty_q <= 1'b0;
        else      dirty_q <= (dirty_q && !frame_start) || wr_ok;
    end
    assign go = dirty_q;
`else
    assign go = 1'b1;
`endif

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        col_d   = col_q;
        if (tick) begin
            cnt_d = cnt_q + 16'd1;
            unique case (state_q)
                S_PWRUP: if (cnt_q == PWR_LAST) begin state_d = S_FUNC;  cnt_d = '0; end
                S_FUNC:  if (cnt_q == CMD_LAST) begin state_d = S_DISP;  cnt_d = '0; end
                S_DISP:  if (cnt_q == CMD_LAST) begin state_d = S_ENTRY; cnt_d = '0; end
                S_ENTRY: if (cnt_q == CMD_LAST) begin state_d = S_CLEAR; cnt_d = '0; end
                S_CLEAR: if (cnt_q == CLR_LAST) begin state_d = S_LADDR; cnt_d = '0; line_d = 1'b0; end
                S_LADDR: begin state_d = S_CHARS; cnt_d = '0; col_d = '0; end
                S_CHARS: begin
                    cnt_d = '0;
                    if (col_q != COL_LAST) begin
                        col_d = col_q + 1'b1;
                    end else if (line_q != LINE_LAST) begin
                        state_d = S_LADDR;
                        line_d  = line_q + 1'b1;
                    end else if (GAP_SLOTS == 0 && go) begin
                        state_d = S_LADDR;
                        line_d  = 1'b0;
                    end else begin
                        state_d = S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_end && go) begin
                        state_d = S_LADDR;
                        cnt_d   = '0;
                        line_d  = 1'b0;
                    end else if (gap_end) begin
                        cnt_d = cnt_q;
                    end
                end
                default: state_d = S_PWRUP;
            endcase
        end
    end

    // Outputs are computed from next-state so the registers line up with the slot they describe.
    assign rd_idx   = IW'(int'(line_d) * COLS + int'(col_d));
    assign strobe_d = (((state_d == S_FUNC) || (state_d == S_DISP) || (state_d == S_ENTRY) ||
                        (state_d == S_CLEAR)) && (cnt_d == '0)) ||
                      (state_d == S_LADDR) || (state_d == S_CHARS);

    always_comb begin
        e_d          = strobe_d && (div_d >= DIV_HALF);
        rs_d         = lcd_rs_q;
        data_d       = lcd_data_q;
        ready_d      = ready_q || (state_d == S_LADDR);
        frame_done_d = frame_end;
        if (tick) begin
            unique case (state_d)
                S_FUNC:  begin rs_d = 1'b0; data_d = FUNC_CMD; end
                S_DISP:  begin rs_d = 1'b0; data_d = 8'h0C; end
                S_ENTRY: begin rs_d = 1'b0; data_d = 8'h06; end
                S_CLEAR: begin rs_d = 1'b0; data_d = 8'h01; end
                S_LADDR: begin rs_d = 1'b0; data_d = line_d ? 8'hC0 : 8'h80; end
                S_CHARS: begin rs_d = 1'b1; data_d = text_q[rd_idx]; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_PWRUP;
            div_q        <= '0;
            cnt_q        <= '0;
            line_q       <= 1'b0;
            col_q        <= '0;
            lcd_e_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            col_q        <= col_d;
            lcd_e_q      <= e_d;
            lcd_rs_q     <= rs_d;
            lcd_data_q   <= data_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Read-before-write falls out of the nonblocking update: the bus latches the old byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) text_q[i] <= 8'h20;
        end else if (wr_ok) begin
            text_q[IW'(wr_addr)] <= wr_data;
        end
    end

    assign lcd_e      = lcd_e_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = lcd_data_q;
    assign ready      = ready_q;
    assign frame_done = frame_done_q;
endmodule
